// File: rtl/lzss_enc_param.sv
// LZSS encoder: stages input words into a look-ahead window and emits one
// {offset, length, next_char} codeword per longest search-buffer match.
module lzss_enc_param #(
  parameter  int SB_DEPTH = 8,
  parameter  int LA_DEPTH = 5,
  parameter  int IN_BYTES = 4,
  localparam int OFF_W    = $clog2(SB_DEPTH),
  localparam int LEN_W    = $clog2(LA_DEPTH),
  localparam int CW_W     = OFF_W + LEN_W + 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*IN_BYTES-1:0] data,
  input  logic                  data_valid,
  input  logic                  data_last,
  output logic                  data_ready,
  output logic [CW_W-1:0]       codeword,
  output logic                  cw_valid,
  input  logic                  cw_ready,
  output logic [11:0]           enc_num,
  output logic                  finish
);
  localparam int SC_W = $clog2(IN_BYTES + 1);
  localparam int LC_W = $clog2(LA_DEPTH + 1);
  localparam int EXT  = SB_DEPTH + LA_DEPTH - 2;

  typedef enum logic [2:0] {IDLE, FILL, COMPARE, EMIT, SHIFT, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [IN_BYTES-1:0][7:0] r_stg;
  logic [SC_W-1:0]          r_stg_cnt;
  logic [LA_DEPTH-1:0][7:0] r_la;
  logic [LC_W-1:0]          r_la_cnt;
  logic [SB_DEPTH-1:0][7:0] r_sb;
  logic [SB_DEPTH-1:0]      r_sb_vld;
  logic                     r_last_acc;
  logic [CW_W-1:0]          r_cw;
  logic [LEN_W-1:0]         r_len;
  logic [11:0]              r_enc;

  logic w_in_fire;
  int   w_la_cnt, w_stg_cnt, w_mv, w_la_nxt, w_stg_nxt, w_shift_n;
  int   w_cap, w_len, w_best_len, w_best_off;
  logic w_run;
  logic [EXT-1:0][7:0] w_ext;
  logic [EXT-1:0]      w_ext_vld;

  assign w_la_cnt   = int'(r_la_cnt);
  assign w_stg_cnt  = int'(r_stg_cnt);
  assign w_shift_n  = int'(r_len) + 1;
  assign data_ready = (r_state != IDLE) && (r_state != DONE) && (r_stg_cnt == '0) && !r_last_acc;
  assign w_in_fire  = data_valid && data_ready;
  assign cw_valid   = (r_state == EMIT);
  assign finish     = (r_state == DONE);
  assign codeword   = r_cw;
  assign enc_num    = r_enc;

  always_comb begin
    w_mv = 0;
    if (r_state == FILL)
      w_mv = (w_stg_cnt < LA_DEPTH - w_la_cnt) ? w_stg_cnt : LA_DEPTH - w_la_cnt;
    w_la_nxt  = w_la_cnt + w_mv;
    w_stg_nxt = w_stg_cnt - w_mv;
  end

  // Search buffer padded with invalid entries so a match can never run into the LA.
  always_comb begin
    w_ext                   = '0;
    w_ext_vld               = '0;
    w_ext[SB_DEPTH-1:0]     = r_sb;
    w_ext_vld[SB_DEPTH-1:0] = r_sb_vld;
    w_cap      = (w_la_cnt == 0) ? 0 : w_la_cnt - 1;
    w_best_len = 0;
    w_best_off = 0;
    w_len      = 0;
    w_run      = 1'b0;
    for (int o = 0; o < SB_DEPTH; o++) begin
      w_len = 0;
      w_run = 1'b1;
      for (int k = 0; k < LA_DEPTH - 1; k++) begin
        if (w_run && (k < w_cap) && w_ext_vld[o+k] && (w_ext[o+k] == r_la[k]))
          w_len = k + 1;
        else
          w_run = 1'b0;
      end
      if (w_len > w_best_len) begin
        w_best_len = w_len;
        w_best_off = o;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = FILL;
      FILL: begin
        if (w_la_nxt == LA_DEPTH)
          w_state_nxt = COMPARE;
        else if (r_last_acc && (w_stg_nxt == 0))
          w_state_nxt = (w_la_nxt == 0) ? DONE : COMPARE;
      end
      COMPARE: w_state_nxt = EMIT;
      EMIT:    if (cw_ready) w_state_nxt = SHIFT;
      SHIFT:   w_state_nxt = FILL;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg      <= '0;
      r_stg_cnt  <= '0;
      r_la       <= '0;
      r_la_cnt   <= '0;
      r_sb       <= '0;
      r_sb_vld   <= '0;
      r_last_acc <= 1'b0;
      r_cw       <= '0;
      r_len      <= '0;
      r_enc      <= '0;
    end else begin
      if (w_in_fire) begin
        for (int i = 0; i < IN_BYTES; i++)
          r_stg[i] <= data[8*(IN_BYTES-i)-1 -: 8];
        r_stg_cnt <= SC_W'(IN_BYTES);
        if (data_last) r_last_acc <= 1'b1;
      end else if (w_mv != 0) begin
        // Staging is kept head-aligned: byte 0 is always the next to move.
        for (int i = 0; i < IN_BYTES; i++)
          if (i + w_mv < IN_BYTES) r_stg[i] <= r_stg[i+w_mv];
        for (int i = 0; i < LA_DEPTH; i++)
          if ((i >= w_la_cnt) && (i < w_la_nxt)) r_la[i] <= r_stg[i-w_la_cnt];
        r_stg_cnt <= SC_W'(w_stg_nxt);
        r_la_cnt  <= LC_W'(w_la_nxt);
      end

      if (r_state == COMPARE) begin
        r_cw  <= {OFF_W'(w_best_off), LEN_W'(w_best_len), r_la[w_best_len]};
        r_len <= LEN_W'(w_best_len);
      end

      if ((r_state == EMIT) && cw_ready && (r_enc != 12'hFFF))
        r_enc <= r_enc + 12'd1;

      if (r_state == SHIFT) begin
        for (int i = 0; i < SB_DEPTH; i++) begin
          if (i + w_shift_n < SB_DEPTH) begin
            r_sb[i]     <= r_sb[i+w_shift_n];
            r_sb_vld[i] <= r_sb_vld[i+w_shift_n];
          end else begin
            r_sb[i]     <= r_la[i+w_shift_n-SB_DEPTH];
            r_sb_vld[i] <= 1'b1;
          end
        end
        for (int i = 0; i < LA_DEPTH; i++)
          if (i + w_shift_n < LA_DEPTH) r_la[i] <= r_la[i+w_shift_n];
        r_la_cnt <= LC_W'(w_la_cnt - w_shift_n);
      end
    end
  end
endmodule
